// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU load/store bridge to a single-port word RAM.
// Latches the request into MAR/MDR, drives big-endian lane-aligned
// accesses, waits for mem_ready with a timeout, and extends load data.
// Optional feature: define ALIGN_CHECK_EN to reject misaligned halfword
// and word requests with err=1 and no RAM access.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        unSign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        moc,
  output logic        busy,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_en,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mar_q, mar_d;
  logic [1:0]        size_q, size_d;
  logic              rw_q, rw_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              moc_q, moc_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;

  logic [3:0]        req_be_c;
  logic [31:0]       req_wd_c;
  logic              misalign_c;
  logic [31:0]       byte_sh_c;
  logic [15:0]       half_c;
  logic [31:0]       load_c;

  // Lane enables, replicated store data and alignment status of the incoming request
  always_comb begin
    req_be_c = 4'b1111;
    req_wd_c = wdata;
    case (size)
      2'b00: begin
        req_be_c = 4'b1000 >> addr[1:0];
        req_wd_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_be_c = 4'b1100 >> {addr[1], 1'b0};
        req_wd_c = {2{wdata[15:0]}};
      end
      default: begin
        req_be_c = 4'b1111;
        req_wd_c = wdata;
      end
    endcase
`ifdef ALIGN_CHECK_EN
    misalign_c = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    misalign_c = 1'b0;
`endif
  end

  // Selected read lane shifted down and extended according to the latched request
  always_comb begin
    byte_sh_c = mem_rdata >> {~mar_q[1:0], 3'b000};
    half_c    = mar_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_q)
      2'b00:   load_c = {{24{byte_sh_c[7] & ~uns_q}}, byte_sh_c[7:0]};
      2'b01:   load_c = {{16{half_c[15] & ~uns_q}}, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mar_d    = mar_q;
    size_d   = size_q;
    rw_d     = rw_q;
    uns_d    = uns_q;
    wdat_d   = wdat_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          mar_d  = addr;
          size_d = size;
          rw_d   = rw;
          uns_d  = unSign;
          wdat_d = req_wd_c;
          be_d   = req_be_c;
          cnt_d  = '0;
          if (misalign_c) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          if (rw_q) rdata_d = load_c;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    moc_d    = (state_d == DONE);
    mem_en_d = (state_d == ACCESS);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mar_q    <= '0;
      size_q   <= '0;
      rw_q     <= 1'b0;
      uns_q    <= 1'b0;
      wdat_q   <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      moc_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mem_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mar_q    <= mar_d;
      size_q   <= size_d;
      rw_q     <= rw_d;
      uns_q    <= uns_d;
      wdat_q   <= wdat_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      moc_q    <= moc_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      mem_en_q <= mem_en_d;
    end
  end

  assign rdata     = rdata_q;
  assign moc       = moc_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign mem_addr  = {mar_q[31:2], 2'b00};
  assign mem_wdata = wdat_q;
  assign mem_be    = be_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = rw_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized bench for mem_bus_ctrl against a byte-level
// big-endian reference model.
module tb_mem_bus_ctrl;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, rw, unSign, mem_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        moc, busy, err, mem_en, mem_rw;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata = 32'h0;

  mem_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .size(size), .unSign(unSign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .moc(moc), .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_en(mem_en),
    .mem_rw(mem_rw), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // first big-endian byte offset covered by the access
  function automatic int start_off(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    int s = start_off(sz, a);
    int n = nbytes(sz);
    logic [3:0] be = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= s && i < s + n) be[3-i] = 1'b1;
    return be;
  endfunction

  // lane i (0 = [31:24]) carries source byte (i mod n), source byte 0 being the MSB of the n-byte value
  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    longint unsigned v = 0;
    for (int i = 0; i < 4; i++)
      v = v * 256 + ((longint'(wd) >> (8 * (n - 1 - (i % n)))) & 255);
    return 32'(v);
  endfunction

  function automatic logic [31:0] exp_ld(input logic [1:0] sz, input logic u,
                                          input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(sz);
    int s = start_off(sz, a);
    longint v = 0;
    for (int j = 0; j < n; j++)
      v = v * 256 + ((longint'(rd) >> (8 * (3 - (s + j)))) & 255);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    bit m = 1'b0;
`ifdef ALIGN_CHECK_EN
    m = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`endif
    return m;
  endfunction

  // one request; mem_ready rises in ACCESS cycle dly (0 = first cycle)
  task automatic run_txn(input logic r, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly);
    int idx;
    int exp_idx;
    logic exp_err;
    bit mis = is_misaligned(sz, a);
    @(posedge clk); #1;
    req = 1'b1; rw = r; size = sz; unSign = u; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_rdata = rd;
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); unSign = ~u;
    idx = 0;
    while (moc !== 1'b1 && idx < 300) begin
      check("access_en", 32'(mem_en), 32'd1);
      check("access_busy", 32'(busy), 32'd1);
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      check("mem_be", 32'(mem_be), 32'(exp_be(sz, a)));
      check("mem_wdata", mem_wdata, exp_wd(sz, wd));
      check("mem_rw", 32'(mem_rw), 32'(r));
      mem_ready = (idx == dly);
      @(posedge clk); #1;
      idx++;
    end
    mem_ready = 1'b0;
    if (mis) begin exp_idx = 0; exp_err = 1'b1; end
    else if (dly < T) begin exp_idx = dly + 1; exp_err = 1'b0; end
    else begin exp_idx = T; exp_err = 1'b1; end
    check("latency", 32'(idx), 32'(exp_idx));
    check("done_moc", 32'(moc), 32'd1);
    check("done_err", 32'(err), 32'(exp_err));
    check("done_en", 32'(mem_en), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    if (!exp_err && r) model_rdata = exp_ld(sz, u, a, rd);
    check("rdata", rdata, model_rdata);
    @(posedge clk); #1;
    check("moc_pulse", 32'(moc), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    req = 1'b0; rw = 1'b0; size = 2'd0; unSign = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_moc", 32'(moc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'(mem_en), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    #1 reset = 1'b0;

    // directed cases
    run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    run_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h0, 32'h112233F0, 0);
    check("byte_signed", rdata, 32'hFFFFFFF0);
    run_txn(1'b1, 2'd0, 1'b1, 32'h13, 32'h0, 32'h112233F0, 0);
    check("byte_unsigned", rdata, 32'h000000F0);
    run_txn(1'b0, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 1);
    check("half_wd_low", 32'(mem_wdata[15:0]), 32'h0000ABCD);
    check("half_be", 32'(mem_be), 32'b0011);
    run_txn(1'b1, 2'd1, 1'b0, 32'h40, 32'h0, 32'h8001_7F00, T + 5);
    check("timeout_keeps", rdata, 32'h000000F0);
    run_txn(1'b1, 2'd3, 1'b0, 32'h6, 32'h0, 32'hCAFEF00D, 2);
    run_txn(1'b1, 2'd1, 1'b0, 32'h44, 32'h0, 32'h1234_8765, T - 1);

    // reset during the second ACCESS cycle
    @(posedge clk); #1;
    req = 1'b1; rw = 1'b1; size = 2'd2; addr = 32'h80; mem_ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_en", 32'(mem_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_moc", 32'(moc), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    model_rdata = 32'h0;
    #3 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_moc", 32'(moc), 32'd0);
    end
    run_txn(1'b1, 2'd2, 1'b0, 32'h84, 32'h0, 32'h0BAD_CAFE, 0);

    // randomized traffic
    for (int t = 0; t < 80; t++) begin
      int d;
      case ($urandom_range(0, 9))
        0:       d = T - 1;
        1:       d = T + $urandom_range(0, 3);
        default: d = $urandom_range(0, 3);
      endcase
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum ACCESS cycles waited for mem_ready, range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 1: CPU request, sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1: 1 = read (load), 0 = write (store).
REQ-006 SHALL have port size, input, 2: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-007 SHALL have port unSign, input, 1: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-008 SHALL have port addr, input, 32: byte address from the ALU result.
REQ-009 SHALL have port wdata, input, 32: store data, right-justified, from register port B.
REQ-010 SHALL have port rdata, output, 32: extended load result (MDR).
REQ-011 SHALL have port moc, output, 1: memory-operation-complete, a one-cycle pulse.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port err, output, 1: error status, valid with moc.
REQ-014 SHALL have port mem_addr, output, 32: word-aligned address (MAR with bits [1:0] forced to 00).
REQ-015 SHALL have port mem_wdata, output, 32: lane-aligned store data.
REQ-016 SHALL have port mem_be, output, 4: byte enables; bit 3 = byte lane [31:24].
REQ-017 SHALL have port mem_en, output, 1: RAM access strobe.
REQ-018 SHALL have port mem_rw, output, 1: copy of the latched rw.
REQ-019 SHALL have port mem_rdata, input, 32: RAM read word.
REQ-020 SHALL have port mem_ready, input, 1: RAM completion, sampled in ACCESS only.

Function
REQ-021 SHALL implement a three-state FSM with states IDLE, ACCESS and DONE.
REQ-022 IDLE: when req=1, SHALL latch addr, size, rw, unSign and the aligned wdata into MAR/MDR and go to ACCESS; when req=0, SHALL stay in IDLE.
REQ-023 ACCESS: SHALL hold mem_en=1; on mem_ready=1 it SHALL capture mem_rdata (reads only) and go to DONE with err=0.
REQ-024 ACCESS: SHALL count cycles; if mem_ready is still 0 after TIMEOUT_CYCLES cycles, it SHALL go to DONE with err=1 and leave rdata unchanged.
REQ-025 DONE: SHALL assert moc=1 for exactly one cycle, then return to IDLE; req is not sampled in DONE.
REQ-026 Minimum latency SHALL be req to moc in 3 cycles, when mem_ready=1 in the first ACCESS cycle.
REQ-027 Byte order SHALL be big-endian: offset 0 maps to lane [31:24]; mem_be = 1000>>addr[1:0] for byte, 1100>>(2*addr[1]) for halfword, 1111 for word.
REQ-028 Store data SHALL be replicated into the selected lane(s); mem_be SHALL also be driven on reads.
REQ-029 Load: the selected lane SHALL be shifted to [7:0] or [15:0], then zero- or sign-extended per unSign; word loads pass through unchanged.
REQ-030 mem_en SHALL be 0 in IDLE and DONE; mem_addr, mem_wdata and mem_be SHALL stay stable for the whole of ACCESS.
REQ-031 rdata SHALL hold its value until the next successful read completes.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, moc=0, err=0, busy=0, mem_en=0, rdata=0, MAR=0 and the timeout counter to 0, including when reset arrives mid-ACCESS; no moc SHALL be issued for an aborted access.

Configuration
REQ-033 With ALIGN_CHECK_EN defined: a halfword request with addr[0]=1, or a word request with addr[1:0]!=00, SHALL go IDLE->DONE with err=1 and mem_en never asserted.
REQ-034 Without ALIGN_CHECK_EN: misalignment SHALL be ignored, with the low address bits used only as in REQ-027 (a misaligned word access uses lanes 1111).

Verification
REQ-035 Word store: addr=0x10, wdata=0xDEADBEEF, mem_ready tied 1 -> mem_addr=0x10, mem_be=1111, mem_wdata=0xDEADBEEF, moc 3 cycles after req, err=0.
REQ-036 Byte load, signed: addr=0x13, unSign=0, mem_rdata=0x112233F0 -> rdata=0xFFFFFFF0; repeat with unSign=1 -> rdata=0x000000F0.
REQ-037 Halfword store: addr=0x22, wdata=0x0000ABCD -> mem_addr=0x20, mem_be=0011, mem_wdata[15:0]=0xABCD.
REQ-038 Timeout: mem_ready held 0, TIMEOUT_CYCLES=15 -> moc with err=1 after 15 ACCESS cycles; rdata keeps its previous value.
REQ-039 Reset in the 2nd ACCESS cycle -> mem_en falls asynchronously, no moc is produced, and the next req completes normally.
REQ-040 With ALIGN_CHECK_EN defined: word read at addr=0x6 -> err=1, moc 2 cycles after req, mem_en never 1.
